// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Active-low font, indexed by hex nibble; segment order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
// Pure table lookup into the shared font.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver with frame-aligned loads.
// Outputs are registered so anode switching is glitch-free.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        CPU_RESETN,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          tick;
  logic          wrap;

  logic [31:0] pend_data;
  logic [7:0]  pend_dp;
  logic        pend_flag;
  logic [31:0] shown_data;
  logic [7:0]  shown_dp;

  logic [3:0] nibble;
  logic [6:0] font_seg;
  logic       blank;

  assign tick = (div_cnt == DIV_MAX);
  assign wrap = tick && (idx == 3'd7);

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A strobe on the wrap cycle lands in pend while shown takes the old pend.
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      shown_data <= '0;
      shown_dp   <= '0;
    end else begin
      if (data_valid) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
      if (wrap && pend_flag) begin
        shown_data <= pend_data;
        shown_dp   <= pend_dp;
      end
    end
  end

  assign nibble = shown_data[{idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (font_seg)
  );

  always_comb begin
    blank = 1'b0;
    if (blank_lz && (idx != 3'd0))
      blank = ((shown_data >> {idx, 2'b00}) == 32'd0);
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      AN  <= AN_OFF;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else if (blank) begin
      AN  <= AN_OFF;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= ~(8'b1 << idx);
      SEG <= font_seg;
      DP  <= ~shown_dp[idx];
    end
  end

endmodule
